// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared types and constants for the branch unit
package core_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic {
        BU_IDLE    = 1'b0,
        BU_PENDING = 1'b1
    } bu_state_e;

    localparam logic [1:0] SNT = 2'd0;
    localparam logic [1:0] WNT = 2'd1;
    localparam logic [1:0] WT  = 2'd2;
    localparam logic [1:0] ST  = 2'd3;

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == ST) ? ST : ctr + 2'd1;
        end
        return (ctr == SNT) ? SNT : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/branch_unit_if.sv
// rtl/branch_unit_if.sv - EX-side branch handshake and fetch redirect bundle
interface branch_unit_if
    import core_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int IMM_W = 16
);
    logic             ex_valid;
    logic             ex_ready;
    logic             ex_is_bne;
    logic             ex_zero;
    logic [XLEN-1:0]  ex_pc;
    logic [XLEN-1:0]  ex_pc_p4;
    logic [IMM_W-1:0] ex_imm;
    logic             ex_pred_taken;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_pc;
    logic             redirect_ack;
    logic             flush;

    modport master (
        output ex_valid, ex_is_bne, ex_zero, ex_pc, ex_pc_p4, ex_imm, ex_pred_taken, redirect_ack,
        input  ex_ready, redirect_valid, redirect_pc, flush
    );

    modport slave (
        input  ex_valid, ex_is_bne, ex_zero, ex_pc, ex_pc_p4, ex_imm, ex_pred_taken, redirect_ack,
        output ex_ready, redirect_valid, redirect_pc, flush
    );

endinterface

// File: rtl/bht_2bit.sv
// rtl/bht_2bit.sv - array of 2-bit saturating counters, async read, one update port
module bht_2bit
    import core_pkg::*;
#(
    parameter int         DEPTH = 64,
    parameter logic [1:0] INIT  = WNT,
    parameter int         IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [1:0]       rd_ctr_o,
    input  logic             upd_en_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic             upd_taken_i
);

    logic [1:0] ctr_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr_q[i] <= INIT;
            end
        end else if (upd_en_i) begin
            ctr_q[upd_idx_i] <= ctr_next(ctr_q[upd_idx_i], upd_taken_i);
        end
    end

    // No bypass: a same-cycle lookup sees the counter before this update lands.
    assign rd_ctr_o = ctr_q[rd_idx_i];

endmodule

// File: rtl/branch_unit.sv
// rtl/branch_unit.sv - BEQ/BNE resolution, BHT prediction and mispredict redirect
// Optional statistics counters: BRANCH_UNIT_STATS_EN
module branch_unit
    import core_pkg::*;
#(
    parameter int         XLEN         = XLEN_DEFAULT,
    parameter int         IMM_W        = 16,
    parameter int         OFFSET_SHIFT = 2,
    parameter int         BHT_DEPTH    = 64,
    parameter logic [1:0] BHT_INIT     = WNT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] fetch_pc,
    output logic            fetch_pred_taken,
    branch_unit_if.slave    bu
`ifdef BRANCH_UNIT_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
`endif
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    bu_state_e       state_q, state_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic            flush_q, flush_d;

    logic [IDX_W-1:0] ex_idx, fetch_idx;
    logic [XLEN-1:0]  imm_sext, target, correct_pc;
    logic             taken, accept, mispredict;
    logic [1:0]       fetch_ctr;

    assign ex_idx    = bu.ex_pc[IDX_W+1:2];
    assign fetch_idx = fetch_pc[IDX_W+1:2];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{fetch_pc[XLEN-1:IDX_W+2], fetch_pc[1:0],
                              bu.ex_pc[XLEN-1:IDX_W+2], bu.ex_pc[1:0]};

    assign imm_sext   = {{(XLEN-IMM_W){bu.ex_imm[IMM_W-1]}}, bu.ex_imm};
    assign target     = bu.ex_pc_p4 + (imm_sext << OFFSET_SHIFT);
    assign taken      = bu.ex_is_bne ? ~bu.ex_zero : bu.ex_zero;
    assign correct_pc = taken ? target : bu.ex_pc_p4;

    assign accept     = bu.ex_valid && (state_q == BU_IDLE);
    assign mispredict = accept && (taken != bu.ex_pred_taken);

    bht_2bit #(
        .DEPTH (BHT_DEPTH),
        .INIT  (BHT_INIT),
        .IDX_W (IDX_W)
    ) u_bht (
        .clk         (clk),
        .rst         (rst),
        .rd_idx_i    (fetch_idx),
        .rd_ctr_o    (fetch_ctr),
        .upd_en_i    (accept),
        .upd_idx_i   (ex_idx),
        .upd_taken_i (taken)
    );

    assign fetch_pred_taken = fetch_ctr[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= BU_IDLE;
            redirect_pc_q <= '0;
            flush_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            redirect_pc_q <= redirect_pc_d;
            flush_q       <= flush_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        redirect_pc_d = redirect_pc_q;
        flush_d       = 1'b0;
        case (state_q)
            BU_IDLE: begin
                if (mispredict) begin
                    state_d       = BU_PENDING;
                    redirect_pc_d = correct_pc;
                    flush_d       = 1'b1;
                end
            end
            BU_PENDING: begin
                if (bu.redirect_ack) begin
                    state_d = BU_IDLE;
                end
            end
            default: state_d = BU_IDLE;
        endcase
    end

    assign bu.ex_ready       = (state_q == BU_IDLE);
    assign bu.redirect_valid = (state_q == BU_PENDING);
    assign bu.redirect_pc    = redirect_pc_q;
    assign bu.flush          = flush_q;

`ifdef BRANCH_UNIT_STATS_EN
    logic [31:0] stat_branches_q, stat_mispredicts_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            if (accept && (stat_branches_q != '1)) begin
                stat_branches_q <= stat_branches_q + 32'd1;
            end
            if (mispredict && (stat_mispredicts_q != '1)) begin
                stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
            end
        end
    end

    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_unit.sv
// tb/tb_branch_unit.sv - directed and randomized checks of branch_unit against a reference model
module tb_branch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fetch_pc;
    logic        fetch_pred_taken;
`ifdef BRANCH_UNIT_STATS_EN
    logic [31:0] stat_branches, stat_mispredicts;
`endif

    branch_unit_if #(.XLEN(32), .IMM_W(16)) bu ();

    branch_unit dut (
        .clk              (clk),
        .rst              (rst),
        .fetch_pc         (fetch_pc),
        .fetch_pred_taken (fetch_pred_taken),
        .bu               (bu)
`ifdef BRANCH_UNIT_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int bht_m [64];
    int n_br = 0;
    int n_mp = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int midx(input logic [31:0] pc);
        return int'((pc / 32'd4) % 32'd64);
    endfunction

    function automatic logic [31:0] next_pc(input bit taken, input logic [31:0] pc, input logic [15:0] imm);
        longint t;
        t = longint'(pc) + 64'sd4 + 64'sd4 * longint'($signed(imm));
        return taken ? t[31:0] : pc + 32'd4;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset;
        for (int i = 0; i < 64; i++) bht_m[i] = 1;
        n_br = 0;
        n_mp = 0;
    endtask

    task automatic present(input bit bne, input bit zero, input logic [31:0] pc,
                           input logic [15:0] imm, input bit pred);
        bu.ex_valid      = 1'b1;
        bu.ex_is_bne     = bne;
        bu.ex_zero       = zero;
        bu.ex_pc         = pc;
        bu.ex_pc_p4      = pc + 32'd4;
        bu.ex_imm        = imm;
        bu.ex_pred_taken = pred;
    endtask

    task automatic branch(input bit bne, input bit zero, input logic [31:0] pc, input logic [15:0] imm,
                          input bit pred, input int hold, input bit early_ack, input bit try_stall);
        bit          taken, mis;
        logic [31:0] expc, stall_pc;
        int          i;
        taken = bne ? !zero : zero;
        mis   = (taken != pred);
        expc  = next_pc(taken, pc, imm);
        i     = midx(pc);
        check("ready_before", bu.ex_ready, 1);
        present(bne, zero, pc, imm, pred);
        fetch_pc = pc;
        if (early_ack) bu.redirect_ack = 1'b1;
        #1;
        check("lookup_pre_update", fetch_pred_taken, (bht_m[i] >= 2));
        tick;
        bu.ex_valid = 1'b0;
        bht_m[i] = taken ? ((bht_m[i] == 3) ? 3 : bht_m[i] + 1) : ((bht_m[i] == 0) ? 0 : bht_m[i] - 1);
        n_br++;
        if (mis) n_mp++;
        check("redirect_valid", bu.redirect_valid, mis);
        check("flush_pulse", bu.flush, mis);
        check("ready_after", bu.ex_ready, !mis);
        if (mis) begin
            check("redirect_pc", bu.redirect_pc, expc);
            if (early_ack) begin
                tick;
                bu.redirect_ack = 1'b0;
                check("early_ack_valid", bu.redirect_valid, 0);
                check("early_ack_flush", bu.flush, 0);
            end else begin
                stall_pc = pc ^ 32'h4;
                for (int h = 0; h < hold; h++) begin
                    if (try_stall && h == 0) present(1'b0, 1'b1, stall_pc, 16'h0040, 1'b0);
                    tick;
                    bu.ex_valid = 1'b0;
                    check("hold_valid", bu.redirect_valid, 1);
                    check("hold_flush", bu.flush, 0);
                    check("hold_ready", bu.ex_ready, 0);
                    check("hold_pc", bu.redirect_pc, expc);
                end
                bu.redirect_ack = 1'b1;
                tick;
                bu.redirect_ack = 1'b0;
                check("ack_valid", bu.redirect_valid, 0);
                if (try_stall && hold > 0) begin
                    fetch_pc = stall_pc;
                    #1;
                    check("stall_no_update", fetch_pred_taken, (bht_m[midx(stall_pc)] >= 2));
                end
            end
        end else if (early_ack) begin
            bu.redirect_ack = 1'b0;
        end
        check("ready_end", bu.ex_ready, 1);
        fetch_pc = pc;
        #1;
        check("lookup_post", fetch_pred_taken, (bht_m[i] >= 2));
    endtask

    task automatic check_stats;
`ifdef BRANCH_UNIT_STATS_EN
        check("stat_branches", stat_branches, n_br);
        check("stat_mispredicts", stat_mispredicts, n_mp);
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rpc;
        bit          rbne, rzero, rpred;
        bu.ex_valid = 0; bu.ex_is_bne = 0; bu.ex_zero = 0; bu.ex_pc = 0;
        bu.ex_pc_p4 = 0; bu.ex_imm = 0; bu.ex_pred_taken = 0; bu.redirect_ack = 0;
        fetch_pc = 32'h0;
        rst = 1'b1;
        model_reset();
        #1;
        check("reset_pred", fetch_pred_taken, 0);
        check("reset_valid", bu.redirect_valid, 0);
        check("reset_flush", bu.flush, 0);
        check("reset_pc", bu.redirect_pc, 0);
        tick;
        tick;
        rst = 1'b0;
        check("release_ready", bu.ex_ready, 1);
        check("release_valid", bu.redirect_valid, 0);
        check_stats();

        branch(1'b0, 1'b1, 32'h100, 16'hFFFE, 1'b0, 3, 1'b0, 1'b1);
        branch(1'b1, 1'b1, 32'h100, 16'h0000, 1'b0, 0, 1'b0, 1'b0);
        branch(1'b0, 1'b1, 32'h40, 16'h0010, 1'b0, 1, 1'b0, 1'b0);
        branch(1'b0, 1'b1, 32'h40, 16'h0010, 1'b0, 1, 1'b0, 1'b0);
        branch(1'b0, 1'b1, 32'h40, 16'h0010, 1'b1, 1, 1'b0, 1'b0);
        branch(1'b0, 1'b1, 32'h40, 16'h0010, 1'b1, 1, 1'b0, 1'b0);
        branch(1'b0, 1'b1, 32'hFFFF_FFF8, 16'h0002, 1'b0, 1, 1'b0, 1'b0);
        branch(1'b1, 1'b0, 32'h200, 16'h0010, 1'b0, 0, 1'b1, 1'b0);
        check_stats();

        present(1'b0, 1'b1, 32'h80, 16'h0004, 1'b0);
        tick;
        bu.ex_valid = 1'b0;
        check("pre_reset_pending", bu.redirect_valid, 1);
        rst = 1'b1;
        model_reset();
        #1;
        check("async_reset_valid", bu.redirect_valid, 0);
        check("async_reset_flush", bu.flush, 0);
        check("async_reset_ready", bu.ex_ready, 1);
        check("async_reset_pc", bu.redirect_pc, 0);
        fetch_pc = 32'h40;
        #1;
        check("async_reset_bht", fetch_pred_taken, 0);
        check_stats();
        tick;
        rst = 1'b0;

        for (int n = 0; n < 150; n++) begin
            rpc   = ($urandom % 8) * 4 + ($urandom % 2) * 256;
            rbne  = $urandom % 2;
            rzero = $urandom % 2;
            rpred = (($urandom % 4) == 0) ? 1'($urandom % 2) : (bht_m[midx(rpc)] >= 2);
            branch(rbne, rzero, rpc, 16'($urandom), rpred, $urandom % 3,
                   (($urandom % 4) == 0), (($urandom % 4) == 0));
        end
        check_stats();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
